// File: rtl/sync2ncl_bridge_pkg.sv
// Shared NCL signal definitions: the dual-rail bit type, its NULL value,
// and the single-rail to dual-rail bit encoder.
package sync2ncl_bridge_pkg;

    // One dual-rail bit: DATA1 = {1,0}, DATA0 = {0,1}, NULL = {0,0}.
    typedef struct packed {
        logic rail1;
        logic rail0;
    } dual_rail_logic;

    localparam dual_rail_logic DR_NULL = '{rail1: 1'b0, rail0: 1'b0};

    // Width of the completed-token counter.
    localparam int TOK_CNT_W = 16;

    // Encode one single-rail bit as a DATA dual-rail bit (never {1,1}).
    function automatic dual_rail_logic dr_encode(input logic b);
        dual_rail_logic r;
        r.rail1 = b;
        r.rail0 = ~b;
        return r;
    endfunction

endpackage

// File: rtl/ncl_ko_sync.sv
// Multi-flop synchronizer bringing the asynchronous NCL ko completion
// signal into the clk domain. All stages clear on reset, so after reset
// the bridge sees RFN until a real RFD has crossed every stage.
module ncl_ko_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Fewer than two stages gives no metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;

    // Shift ko through the synchronizer chain; the oldest stage is the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync2ncl_bridge.sv
// Bridge from a synchronous valid/ready word stream into a 4-phase NCL
// dual-rail pipeline. A one-word holding buffer decouples the producer;
// a two-state FSM alternates DATA and NULL wavefronts on dr_out, paced
// by the synchronized downstream completion ko_s.
module sync2ncl_bridge
    import sync2ncl_bridge_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       ko,
    output dual_rail_logic [WIDTH-1:0] dr_out,
    output logic                       busy,
    output logic [TOK_CNT_W-1:0]       tok_cnt
);

    typedef enum logic {
        S_NULL = 1'b0,  // dr_out NULL, waiting for RFD and a buffered word
        S_DATA = 1'b1   // dr_out DATA, waiting for RFN
    } state_t;

    state_t                     state_q, state_d;
    logic                       ko_s;
    logic                       full_q;
    logic [WIDTH-1:0]           buf_q;
    logic                       capture;
    logic                       launch;
    logic                       retire;
    dual_rail_logic [WIDTH-1:0] dr_q;
    dual_rail_logic [WIDTH-1:0] dr_enc;
    logic [TOK_CNT_W-1:0]       tok_cnt_q;

    ncl_ko_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ko_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ko),
        .q    (ko_s)
    );

    // The buffer accepts only when empty. A launch needs full=1, so a
    // capture can never share an edge with a launch: the next word always
    // waits one edge after the current one leaves the buffer.
    assign in_ready = ~full_q;
    assign capture  = in_valid & in_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state_q <= S_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the launch/retire strobes for the datapath.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        launch  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_NULL: begin
                if (ko_s && full_q) begin
                    state_d = S_DATA;
                    launch  = 1'b1;
                end
            end
            S_DATA: begin
                if (!ko_s) begin
                    state_d = S_NULL;
                    retire  = 1'b1;
                end
            end
            default: begin
                state_d = S_NULL;
            end
        endcase
    end

    // Holding-buffer full flag: set on capture, cleared on launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (capture) begin
            full_q <= 1'b1;
        end else if (launch) begin
            full_q <= 1'b0;
        end
    end

    // Holding-buffer payload, written only on capture.
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset; full_q qualifies it, so its
        // contents after reset are never observed.
        if (capture) begin
            buf_q <= in_data;
        end
    end

    // Dual-rail encoding of the buffered word, used at launch.
    always_comb begin
        dr_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dr_enc[i] = dr_encode(buf_q[i]);
        end
    end

    // Registered dual-rail bus: whole-word DATA on launch, whole-word NULL
    // on retire, otherwise held so DATA is stable for the entire S_DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                dr_q[i] <= DR_NULL;
            end
        end else if (launch) begin
            dr_q <= dr_enc;
        end else if (retire) begin
            for (int i = 0; i < WIDTH; i++) begin
                dr_q[i] <= DR_NULL;
            end
        end
    end

    // Completed DATA/NULL cycle counter; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_cnt_q <= '0;
        end else if (retire) begin
            tok_cnt_q <= tok_cnt_q + 1'b1;
        end
    end

    assign dr_out  = dr_q;
    assign tok_cnt = tok_cnt_q;
    assign busy    = full_q | (state_q == S_DATA);

endmodule

// File: tb/tb_sync2ncl_bridge.sv
// Self-checking bench for sync2ncl_bridge: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_sync2ncl_bridge;
    import sync2ncl_bridge_pkg::*;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;

    logic                       clk      = 1'b0;
    logic                       rst_n    = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       ko       = 1'b0;
    logic [WIDTH-1:0]           in_data  = '0;
    logic                       in_ready;
    logic                       busy;
    dual_rail_logic [WIDTH-1:0] dr_out;
    logic [15:0]                tok_cnt;
    logic [2*WIDTH-1:0]         dr_flat;

    int tests_run    = 0;
    int tests_failed = 0;

    assign dr_flat = dr_out;

    sync2ncl_bridge #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .ko      (ko),
        .dr_out  (dr_out),
        .busy    (busy),
        .tok_cnt (tok_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // ko samples still in flight (front = value the bridge acts on now),
    // words waiting in the buffer, the word on the bus, completed tokens.
    bit               m_ko[$];
    logic [WIDTH-1:0] m_buf[$];
    bit               m_data_on;
    logic [WIDTH-1:0] m_word;
    logic [15:0]      m_tok;

    task automatic model_reset();
        m_ko.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_ko.push_back(1'b0);
        m_buf.delete();
        m_data_on = 1'b0;
        m_word    = '0;
        m_tok     = '0;
    endtask

    // Apply one clock edge's worth of protocol rules using pre-edge inputs.
    task automatic model_edge();
        bit kos;
        bit cap;
        kos = m_ko[0];
        cap = in_valid && (m_buf.size() == 0);
        void'(m_ko.pop_front());
        m_ko.push_back(ko);
        if (m_data_on) begin
            if (!kos) begin
                m_data_on = 1'b0;
                m_tok     = m_tok + 16'd1;
            end
        end else if (kos && m_buf.size() != 0) begin
            m_word    = m_buf.pop_front();
            m_data_on = 1'b1;
        end
        if (cap) m_buf.push_back(in_data);
    endtask

    // DATA wavefront of a word: rail1 = bit, rail0 = inverted bit.
    function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] w);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = w[i];
            r[2*i]   = ~w[i];
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] model_dr();
        return m_data_on ? enc(m_word) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] rail1_of(input logic [2*WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rail0_of(input logic [2*WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = v[2*i];
        return r;
    endfunction

    // Advance DUT and model by one edge; outputs are sampled 1 unit later.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: no bit shows {1,1}, and the bus is all-NULL or all-DATA.
    always @(negedge clk) begin
        if (rst_n) begin
            int n_null;
            int n_illegal;
            n_null    = 0;
            n_illegal = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if (dr_flat[2*i+1] && dr_flat[2*i]) n_illegal++;
                if (!dr_flat[2*i+1] && !dr_flat[2*i]) n_null++;
            end
            tests_run++;
            assert (n_illegal == 0 && (n_null == 0 || n_null == WIDTH))
            else begin
                tests_failed++;
                $display("FAIL dr_legal: dr_out=%h has %0d illegal bits, %0d null bits", dr_flat, n_illegal, n_null);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        #2;
        tests_run += 4;
        if (dr_flat !== '0)    begin tests_failed++; $display("FAIL reset_dr: got %h want 0", dr_flat); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (tok_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_tok: got %0d want 0", tok_cnt); end
        @(posedge clk);
        #1;
        tests_run += 2;
        if (dr_flat !== '0)    begin tests_failed++; $display("FAIL reset_dr_clk: got %h want 0", dr_flat); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready_clk: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_token();
        int n;
        ko       = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        n        = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            in_valid = 1'b0;
            n = k;
            if (dr_flat != '0) break;
        end
        tests_run += 5;
        if (n !== SYNC_STAGES + 1)      begin tests_failed++; $display("FAIL first_latency: got %0d edges want %0d", n, SYNC_STAGES + 1); end
        if (rail1_of(dr_flat) !== 8'hA5) begin tests_failed++; $display("FAIL first_rail1: got %h want a5", rail1_of(dr_flat)); end
        if (rail0_of(dr_flat) !== 8'h5A) begin tests_failed++; $display("FAIL first_rail0: got %h want 5a", rail0_of(dr_flat)); end
        if (tok_cnt !== 16'd0)           begin tests_failed++; $display("FAIL first_tok: got %0d want 0", tok_cnt); end
        if (busy !== 1'b1)               begin tests_failed++; $display("FAIL first_busy: got %b want 1", busy); end
    endtask

    task automatic test_rfn();
        ko = 1'b0;
        repeat (SYNC_STAGES) cycle();
        tests_run++;
        if (dr_flat !== enc(8'hA5)) begin tests_failed++; $display("FAIL rfn_hold: got %h want %h", dr_flat, enc(8'hA5)); end
        cycle();
        tests_run += 3;
        if (dr_flat !== '0)    begin tests_failed++; $display("FAIL rfn_null: got %h want 0", dr_flat); end
        if (tok_cnt !== 16'd1) begin tests_failed++; $display("FAIL rfn_tok: got %0d want 1", tok_cnt); end
        if (busy !== 1'b0)     begin tests_failed++; $display("FAIL rfn_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w[2];
        int idx;
        bit done;
        bit did_cap;
        w[0] = 8'h01;
        w[1] = 8'h02;
        idx  = 0;
        done = 1'b0;
        ko   = 1'b1;
        for (int k = 0; k < 30 && !done; k++) begin
            in_valid = (idx < 2);
            in_data  = w[idx % 2];
            did_cap  = in_valid && in_ready;
            cycle();
            if (did_cap) idx++;
            if (idx == 2 && dr_flat != '0) done = 1'b1;
        end
        in_valid = 1'b0;
        tests_run += 4;
        if (!done)                     begin tests_failed++; $display("FAIL b2b_timeout: captured %0d words", idx); end
        if (dr_flat !== enc(8'h01))    begin tests_failed++; $display("FAIL b2b_first: got %h want %h", dr_flat, enc(8'h01)); end
        if (in_ready !== 1'b0)         begin tests_failed++; $display("FAIL b2b_ready_full: got %b want 0", in_ready); end
        if (busy !== 1'b1)             begin tests_failed++; $display("FAIL b2b_busy: got %b want 1", busy); end
        ko = 1'b0;
        repeat (SYNC_STAGES + 1) cycle();
        tests_run += 2;
        if (dr_flat !== '0)    begin tests_failed++; $display("FAIL b2b_null: got %h want 0", dr_flat); end
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_null: got %b want 0", in_ready); end
        ko   = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            cycle();
            if (dr_flat != '0) begin
                done = 1'b1;
            end else begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_wait: got %b want 0", in_ready); end
            end
        end
        tests_run += 2;
        if (dr_flat !== enc(8'h02)) begin tests_failed++; $display("FAIL b2b_second: got %h want %h", dr_flat, enc(8'h02)); end
        if (in_ready !== 1'b1)      begin tests_failed++; $display("FAIL b2b_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_stall();
        ko       = 1'b0;
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        cycle();
        in_valid = 1'b0;
        repeat (SYNC_STAGES + 1) cycle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            tests_run += 3;
            if (dr_flat !== '0)    begin tests_failed++; $display("FAIL stall_dr: cycle %0d got %h want 0", k, dr_flat); end
            if (busy !== 1'b1)     begin tests_failed++; $display("FAIL stall_busy: cycle %0d got %b want 1", k, busy); end
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready: cycle %0d got %b want 0", k, in_ready); end
        end
    endtask

    task automatic test_reset_mid_data();
        int n;
        logic [WIDTH-1:0] w;
        ko = 1'b1;
        for (int k = 0; k < 10 && dr_flat == '0; k++) cycle();
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        cycle();
        in_valid = 1'b0;
        tests_run += 2;
        if (dr_flat === '0)  begin tests_failed++; $display("FAIL mid_pre_data: got %h want DATA", dr_flat); end
        if (tok_cnt !== m_tok) begin tests_failed++; $display("FAIL mid_pre_tok: got %0d want %0d", tok_cnt, m_tok); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests_run += 4;
        if (dr_flat !== '0)    begin tests_failed++; $display("FAIL mid_dr: got %h want 0", dr_flat); end
        if (tok_cnt !== 16'd0) begin tests_failed++; $display("FAIL mid_tok: got %0d want 0", tok_cnt); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0)     begin tests_failed++; $display("FAIL mid_busy: got %b want 0", busy); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        // ko is already 1; the first launch must still wait out the synchronizer.
        w        = WIDTH'($urandom);
        in_valid = 1'b1;
        in_data  = w;
        n        = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            in_valid = 1'b0;
            n = k;
            tests_run++;
            if (dr_flat !== model_dr()) begin tests_failed++; $display("FAIL post_rst_dr: got %h want %h", dr_flat, model_dr()); end
            if (dr_flat != '0) break;
        end
        tests_run += 2;
        if (n !== SYNC_STAGES + 1)  begin tests_failed++; $display("FAIL post_rst_latency: got %0d want %0d", n, SYNC_STAGES + 1); end
        if (rail1_of(dr_flat) !== w) begin tests_failed++; $display("FAIL post_rst_word: got %h want %h", rail1_of(dr_flat), w); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) ko = ~ko;
            cycle();
            tests_run += 4;
            if (dr_flat !== model_dr())                  begin tests_failed++; $display("FAIL rand_dr: cycle %0d got %h want %h", k, dr_flat, model_dr()); end
            if (in_ready !== (m_buf.size() == 0))        begin tests_failed++; $display("FAIL rand_ready: cycle %0d got %b want %b", k, in_ready, m_buf.size() == 0); end
            if (busy !== (m_buf.size() != 0 || m_data_on)) begin tests_failed++; $display("FAIL rand_busy: cycle %0d got %b want %b", k, busy, m_buf.size() != 0 || m_data_on); end
            if (tok_cnt !== m_tok)                       begin tests_failed++; $display("FAIL rand_tok: cycle %0d got %0d want %0d", k, tok_cnt, m_tok); end
        end
    endtask

    // Preload the counter near the top so the wrap is reached in a few
    // dozen tokens instead of 65536.
    task automatic test_wrap();
        logic [15:0] prev;
        bit saw_wrap;
        force dut.tok_cnt_q = 16'hFFF0;
        #1;
        release dut.tok_cnt_q;
        m_tok    = 16'hFFF0;
        prev     = 16'hFFF0;
        saw_wrap = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            in_data = WIDTH'($urandom);
            ko      = ~ko;
            cycle();
            tests_run += 2;
            if (tok_cnt !== m_tok)      begin tests_failed++; $display("FAIL wrap_tok: cycle %0d got %h want %h", k, tok_cnt, m_tok); end
            if (dr_flat !== model_dr()) begin tests_failed++; $display("FAIL wrap_dr: cycle %0d got %h want %h", k, dr_flat, model_dr()); end
            if (prev == 16'hFFFF && tok_cnt == 16'h0000) saw_wrap = 1'b1;
            prev = tok_cnt;
        end
        in_valid = 1'b0;
        tests_run++;
        if (!saw_wrap) begin tests_failed++; $display("FAIL wrap_seen: tok_cnt never went ffff->0, ended at %h", tok_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_token();
        test_rfn();
        test_back_to_back();
        test_stall();
        test_reset_mid_data();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
